// File: rtl/prbs_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// prbs_sequencer_pkg
// Shared definitions for the PRBS9 I/Q sequencer: FSM state encoding,
// default oversampling / warmup constants and a constant-foldable clog2.
// ---------------------------------------------------------------------------
package prbs_sequencer_pkg;

  localparam int unsigned DEF_NOS    = 4;
  localparam int unsigned DEF_WARMUP = 2;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_WARM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = unsigned'(i + 1);
      end
    end
    return result;
  endfunction

endpackage : prbs_sequencer_pkg

// File: rtl/prbs_tick_gen.sv
// ---------------------------------------------------------------------------
// prbs_tick_gen
// Mod-NOS symbol tick counter with a phase compare. The enable strobe is a
// flop whose value in a cycle equals (tick == phase) for that same cycle,
// qualified by the gate requested one cycle earlier.
//
// Ports:
//   clock     in   system clock
//   i_reset   in   asynchronous active-low reset
//   i_clear   in   tick of the next cycle is forced to 0
//   i_run     in   tick of the next cycle advances (mod NOS)
//   i_gate    in   an enable may be issued in the next cycle
//   i_phase   in   clock slot in the symbol period that carries the enable
//   o_enable  out  registered one-cycle symbol-rate strobe
// ---------------------------------------------------------------------------
module prbs_tick_gen
  import prbs_sequencer_pkg::*;
#(
  parameter int unsigned NOS     = DEF_NOS,
  parameter int unsigned PHASE_W = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_run,
  input  logic               i_gate,
  input  logic [PHASE_W-1:0] i_phase,
  output logic               o_enable
);

  localparam int unsigned TICK_W_RAW = clog2(NOS);
  localparam int unsigned TICK_W     = (TICK_W_RAW < 1) ? 1 : TICK_W_RAW;

  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_nxt;
  logic              w_hit;
  logic              r_enable;

  // Next tick value: clear has priority, otherwise wrap at NOS-1.
  always_comb begin
    w_tick_nxt = r_tick;
    if (i_clear) begin
      w_tick_nxt = '0;
    end else if (i_run) begin
      if (r_tick == TICK_W'(NOS - 1)) begin
        w_tick_nxt = '0;
      end else begin
        w_tick_nxt = r_tick + TICK_W'(1);
      end
    end
  end

  // Compare against the upcoming tick so the strobe lands on tick == phase.
  assign w_hit = (32'(w_tick_nxt) == 32'(i_phase));

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick   <= '0;
      r_enable <= 1'b0;
    end else begin
      r_tick   <= w_tick_nxt;
      r_enable <= i_gate & w_hit;
    end
  end

  assign o_enable = r_enable;

endmodule : prbs_tick_gen

// File: rtl/prbs_sequencer.sv
// ---------------------------------------------------------------------------
// prbs_sequencer
// Sequences reseed and symbol-rate advance strobes for the dual I/Q PRBS9
// generator. After a start it reseeds, discards WARMUP pipeline-fill
// symbols, then flags valid symbols either for a fixed-length burst or
// continuously until stopped.
//
// Ports:
//   clock          in   system clock
//   i_reset        in   asynchronous active-low reset
//   i_start        in   start request (IDLE only)
//   i_stop         in   abort back to IDLE, wins over start
//   i_continuous   in   run until stopped, burst length ignored
//   i_burst_len    in   valid symbols per burst, latched on start
//   i_phase        in   enable slot within the symbol period, latched on start
//   o_prbs_reset   out  one-cycle reseed strobe
//   o_prbs_enable  out  one-cycle advance strobe, one per NOS clocks
//   o_sym_valid    out  PRBS I/Q outputs valid this cycle
//   o_busy         out  high in SEED, WARM and RUN
//   o_done         out  one-cycle pulse on normal burst completion
//   o_sym_count    out  valid symbols issued since start
// ---------------------------------------------------------------------------
module prbs_sequencer
  import prbs_sequencer_pkg::*;
#(
  parameter int unsigned NOS     = DEF_NOS,
  parameter int unsigned PHASE_W = 2,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned WARMUP  = DEF_WARMUP
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_continuous,
  input  logic [LEN_W-1:0]   i_burst_len,
  input  logic [PHASE_W-1:0] i_phase,
  output logic               o_prbs_reset,
  output logic               o_prbs_enable,
  output logic               o_sym_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [LEN_W-1:0]   o_sym_count
);

  localparam int unsigned WARM_W_RAW = clog2(WARMUP + 1);
  localparam int unsigned WARM_W     = (WARM_W_RAW < 1) ? 1 : WARM_W_RAW;
  localparam int unsigned CNT_EXT_W  = LEN_W + 1;

  state_e             r_state;
  logic               r_prbs_reset;
  logic               r_sym_valid;
  logic               r_busy;
  logic               r_done;
  logic [LEN_W-1:0]   r_sym_count;
  logic [LEN_W-1:0]   r_burst_len;
  logic               r_continuous;
  logic [PHASE_W-1:0] r_phase;
  logic [WARM_W-1:0]  r_warm_cnt;

  logic               w_enable;
  logic               w_tick_clear;
  logic               w_tick_run;
  logic               w_tick_gate;
  logic [PHASE_W-1:0] w_phase_clamped;
  logic               w_burst_empty;
  logic               w_room;
  logic               w_last;

  // Out-of-range phase selects collapse onto the last slot of the period.
  assign w_phase_clamped = (32'(i_phase) >= NOS) ? PHASE_W'(NOS - 1) : i_phase;

  assign w_burst_empty = ~r_continuous && (r_burst_len == '0);

  // Room for another symbol: count plus any symbol still in flight.
  assign w_room = (CNT_EXT_W'(r_sym_count) + CNT_EXT_W'(w_enable))
                  < CNT_EXT_W'(r_burst_len);

  // Final valid pulse of a fixed-length burst is showing this cycle.
  assign w_last = ~r_continuous && r_sym_valid && (r_sym_count == r_burst_len);

  // Tick generator control; gate is withdrawn on stop so nothing new issues.
  always_comb begin
    w_tick_clear = 1'b0;
    w_tick_run   = 1'b0;
    w_tick_gate  = 1'b0;
    case (r_state)
      ST_SEED: begin
        w_tick_clear = 1'b1;
        w_tick_gate  = ~i_stop & ~w_burst_empty;
      end
      ST_WARM: begin
        w_tick_run  = ~i_stop;
        w_tick_gate = ~i_stop;
      end
      ST_RUN: begin
        w_tick_run  = ~i_stop;
        w_tick_gate = ~i_stop & (r_continuous | w_room);
      end
      default: begin
        w_tick_run = 1'b0;
      end
    endcase
  end

  prbs_tick_gen #(
    .NOS     (NOS),
    .PHASE_W (PHASE_W)
  ) u_tick_gen (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_clear  (w_tick_clear),
    .i_run    (w_tick_run),
    .i_gate   (w_tick_gate),
    .i_phase  (r_phase),
    .o_enable (w_enable)
  );

  // Sequencer FSM with warmup and symbol counters.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_prbs_reset <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sym_count  <= '0;
      r_burst_len  <= '0;
      r_continuous <= 1'b0;
      r_phase      <= '0;
      r_warm_cnt   <= '0;
    end else begin
      r_prbs_reset <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_burst_len  <= i_burst_len;
            r_continuous <= i_continuous;
            r_phase      <= w_phase_clamped;
            r_sym_count  <= '0;
            r_warm_cnt   <= '0;
            r_prbs_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_SEED;
          end
        end
        ST_SEED: begin
          if (i_stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_burst_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (WARMUP == 0) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_WARM;
          end
        end
        ST_WARM: begin
          if (i_stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_enable) begin
            // Pipeline-fill symbols advance the generator but are never flagged.
            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
            if (r_warm_cnt == WARM_W'(WARMUP - 1)) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            // In-flight symbol is dropped and the count freezes.
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            if (w_enable) begin
              r_sym_valid <= 1'b1;
              r_sym_count <= r_sym_count + LEN_W'(1);
            end
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_prbs_reset  = r_prbs_reset;
  assign o_prbs_enable = w_enable;
  assign o_sym_valid   = r_sym_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_sym_count   = r_sym_count;

endmodule : prbs_sequencer

// File: doc/prbs_sequencer.md
Name: prbs_sequencer

Overview:
- Controller for the dual I/Q PRBS9 generator. Sequences its synchronous reset and enable strobes at the symbol rate.
- The enable rate is one symbol per NOS clocks, with a programmable sampling phase.
- Discards pipeline-fill symbols, counts valid symbols, and runs either fixed-length bursts or continuous streams.
- Sits between the test/control FSM and the PRBS generator feeding the I/Q symbol mapper.

Parameters:
- NOS, 4, oversampling factor: clocks per symbol (>=2).
- PHASE_W, 2, width of phase select (clog2(NOS)).
- LEN_W, 16, width of burst length and symbol counter.
- WARMUP, 2, enable pulses issued after seeding before symbols are valid.

Ports:
- clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  start request, sampled in IDLE only.
- i_stop  in  1  abort; returns to IDLE from any state.
- i_continuous  in  1  1 = run until i_stop; burst length ignored.
- i_burst_len  in  LEN_W  number of valid symbols per burst, latched on start.
- i_phase  in  PHASE_W  clock slot within the symbol period for the enable, latched on start.
- o_prbs_reset  out  1  one-cycle synchronous reset (reseed) to the PRBS generator.
- o_prbs_enable  out  1  one-cycle symbol-rate advance strobe to the PRBS generator.
- o_sym_valid  out  1  PRBS I/Q outputs are valid this cycle.
- o_busy  out  1  high in SEED, WARM and RUN.
- o_done  out  1  one-cycle pulse on normal burst completion.
- o_sym_count  out  LEN_W  valid symbols issued since start.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Tick, warmup and symbol counters 0.
  - Latched config 0.
- All outputs are registered.
- States: IDLE, SEED, WARM, RUN, DONE.
- IDLE:
  - When i_start=1 and i_stop=0: latch i_burst_len, i_continuous and i_phase, then go to SEED.
  - If the latched phase >= NOS, clamp it to NOS-1.
  - If start and stop arrive in the same cycle, stop wins and the block stays in IDLE.
- SEED:
  - Exactly one cycle, with o_prbs_reset=1.
  - Tick counter cleared to 0; o_sym_count cleared.
  - Next state is WARM. If the burst is non-continuous and burst_len==0, next state is DONE instead.
- Tick counter:
  - Mod-NOS, counting 0..NOS-1 with wrap, active in WARM and RUN.
  - o_prbs_enable is high for one cycle each time tick==phase.
  - Consecutive enables are exactly NOS cycles apart.
- Timing (i_start sampled at cycle t):
  - o_prbs_reset at t+1.
  - First o_prbs_enable at t+2+phase.
- WARM:
  - The first WARMUP enables are issued with o_sym_valid held at 0.
  - After the WARMUP-th enable, go to RUN.
- RUN:
  - Each enable is followed one cycle later by o_sym_valid=1; o_sym_count increments in that same cycle.
  - Non-continuous: after the enable that produces symbol number burst_len, issue no further enables. Then:
    - the final o_sym_valid pulse;
    - DONE on the following cycle.
  - Continuous: o_sym_count wraps from 2^LEN_W-1 to 0 and the block never enters DONE.
- DONE:
  - One cycle: o_done=1, o_busy=0.
  - Then IDLE.
  - o_sym_count holds its final value until the next start.
- i_stop=1 in SEED, WARM or RUN:
  - On the next cycle the state is IDLE with o_busy=0, o_prbs_enable=0 and o_sym_valid=0.
  - No o_done pulse.
  - o_sym_count is frozen.
  - A symbol already in flight (enable issued previously) does not raise o_sym_valid.
- i_start while busy is ignored. Config inputs are don't-care outside the start cycle.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous). The block resumes in IDLE after release.
- o_prbs_enable and o_prbs_reset are never high in the same cycle.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, SEED=1, WARM=2, RUN=3, DONE=4, 3 bits);
  - default NOS/WARMUP constants;
  - clog2 function for PHASE_W.
- One natural sub-module, prbs_tick_gen:
  - mod-NOS counter with clear, run and phase compare;
  - outputs the enable strobe.
- The FSM, warmup counter and symbol counter stay in prbs_sequencer.

Test Plan:
- NOS=4, phase=1, burst_len=3, start at t -> o_prbs_reset at t+1; enables at t+3,7,11,15,19; o_sym_valid at t+12,16,20; o_sym_count 1,2,3; o_done at t+21; o_busy high t+1..t+20.
- i_phase=7 with PHASE_W=3, NOS=4 -> phase clamped to 3; first enable at t+5; enable spacing 4 cycles.
- burst_len=0, non-continuous -> o_prbs_reset at t+1, o_done at t+2, no enable, o_sym_count=0.
- Continuous, LEN_W=4 -> o_sym_count runs 1..15, 0, 1; no o_done; i_stop at arbitrary cycle -> next cycle busy=0, no strobes, count frozen.
- i_start and i_stop together in IDLE -> stays IDLE; i_start pulsed again mid-RUN -> ignored, burst completes unchanged.
- Async reset asserted mid-RUN, off a clock edge -> all outputs 0 immediately; after release, a new start produces the same timing as the first scenario.
